// File: rtl/hex_scroller.sv
// Marquee driver: shows a circular message of 7-segment glyphs through a window
// of digits, stepping one glyph every STEP_CYCLES clocks in either direction.
module hex_scroller #(
  parameter int unsigned N_DIGITS    = 6,
  parameter int unsigned MSG_LEN     = 16,
  parameter int unsigned STEP_CYCLES = 12500000,
  localparam int unsigned PosW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  dir,
  input  logic                  restart,
  input  logic [MSG_LEN*7-1:0]  msg,
  output logic [N_DIGITS*7-1:0] hex,
  output logic [PosW-1:0]       pos,
  output logic                  wrap
);

  localparam int unsigned CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned SumW = PosW + 1;

  localparam logic [6:0]      Blank   = 7'h7F;
  localparam logic [PosW-1:0] LastPos = PosW'(MSG_LEN - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(STEP_CYCLES - 1);

  logic [CntW-1:0]       presc_q, presc_d;
  logic [PosW-1:0]       pos_q, pos_d;
  logic                  wrap_q, wrap_d;
  logic [N_DIGITS*7-1:0] hex_q, hex_d;
  logic                  step;

  logic [6:0] glyphs [MSG_LEN];

  for (genvar i = 0; i < MSG_LEN; i++) begin : g_glyph
    assign glyphs[i] = msg[7*i+6:7*i];
  end

  // Digit N_DIGITS-1-k shows glyph (pos+k) mod MSG_LEN. The offset k mod MSG_LEN is
  // a constant per digit and pos < MSG_LEN, so a single conditional subtract wraps it.
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    localparam int unsigned Off = k % MSG_LEN;

    logic [SumW-1:0] sum;
    logic [PosW-1:0] idx;

    assign sum = {1'b0, pos_q} + SumW'(Off);
    assign idx = (sum >= SumW'(MSG_LEN)) ? PosW'(sum - SumW'(MSG_LEN)) : sum[PosW-1:0];
    assign hex_d[7*(N_DIGITS-1-k) +: 7] = glyphs[idx];
  end

  assign step = run && (presc_q == LastCnt);

  always_comb begin
    presc_d = presc_q;
    pos_d   = pos_q;
    wrap_d  = 1'b0;
    if (restart) begin
      // Restart beats a coincident step: no advance and no wrap pulse.
      presc_d = '0;
      pos_d   = '0;
    end else begin
      if (run) begin
        presc_d = step ? '0 : presc_q + CntW'(1);
      end
      if (step) begin
        if (!dir) begin
          if (pos_q == LastPos) begin
            pos_d  = '0;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q + PosW'(1);
          end
        end else begin
          if (pos_q == '0) begin
            pos_d  = LastPos;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q - PosW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      pos_q   <= '0;
      wrap_q  <= 1'b0;
      hex_q   <= {N_DIGITS{Blank}};
    end else begin
      presc_q <= presc_d;
      pos_q   <= pos_d;
      wrap_q  <= wrap_d;
      hex_q   <= hex_d;
    end
  end

  assign hex  = hex_q;
  assign pos  = pos_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_hex_scroller.sv
// Directed bench for hex_scroller: 4 digits, 8-glyph "ALMATY  " message, 3-clock step.
module tb_hex_scroller;

  localparam logic [55:0] Msg = {7'h7F, 7'h7F, 7'h11, 7'h07, 7'h08, 7'h6A, 7'h47, 7'h08};
  localparam logic [27:0] Blank4 = {4{7'h7F}};
  localparam logic [27:0] Alma = {7'h08, 7'h47, 7'h6A, 7'h08};
  localparam logic [27:0] Lmat = {7'h47, 7'h6A, 7'h08, 7'h07};
  localparam logic [27:0] Bbal = {7'h7F, 7'h7F, 7'h08, 7'h47};
  localparam logic [27:0] Balm = {7'h7F, 7'h08, 7'h47, 7'h6A};

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        dir;
  logic        restart;
  logic [55:0] msg;
  logic [27:0] hex;
  logic [2:0]  pos;
  logic        wrap;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hex_scroller #(
    .N_DIGITS   (4),
    .MSG_LEN    (8),
    .STEP_CYCLES(3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .dir    (dir),
    .restart(restart),
    .msg    (msg),
    .hex    (hex),
    .pos    (pos),
    .wrap   (wrap)
  );

  function automatic logic [27:0] win(input logic [55:0] m, input int p);
    logic [27:0] r;
    for (int k = 0; k < 4; k++) r[7*(3-k) +: 7] = m[7*((p+k)%8) +: 7];
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expects to be entered just after reset release, with run=1, dir=0.
  task automatic check_start(input string tag);
    tick(1);
    checks++;
    if (hex !== Alma) begin
      failures++;
      $display("FAIL %s first_window hex=%h expected=%h", tag, hex, Alma);
    end
    checks++;
    if (pos !== 3'd0) begin
      failures++;
      $display("FAIL %s pos_after_release pos=%0d expected=0", tag, pos);
    end
    tick(2);
    checks++;
    if (pos !== 3'd1) begin
      failures++;
      $display("FAIL %s first_step pos=%0d expected=1", tag, pos);
    end
    checks++;
    if (hex !== Alma) begin
      failures++;
      $display("FAIL %s hex_lag hex=%h expected=%h", tag, hex, Alma);
    end
    tick(1);
    checks++;
    if (hex !== Lmat) begin
      failures++;
      $display("FAIL %s second_window hex=%h expected=%h", tag, hex, Lmat);
    end
    checks++;
    if (wrap !== 1'b0) begin
      failures++;
      $display("FAIL %s no_wrap wrap=%b expected=0", tag, wrap);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run = 1'b1;
    dir = 1'b0;
    restart = 1'b0;
    msg = Msg;
    tick(2);
    checks++;
    if (hex !== Blank4) begin
      failures++;
      $display("FAIL reset_hex hex=%h expected=%h", hex, Blank4);
    end
    checks++;
    if (pos !== 3'd0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_pos_wrap pos=%0d wrap=%b expected 0/0", pos, wrap);
    end
    reset = 1'b0;
    check_start("start");
  endtask

  task automatic test_scroll_left();
    tick(2);
    checks++;
    if (pos !== 3'd2) begin
      failures++;
      $display("FAIL left_pos2 pos=%0d expected=2", pos);
    end
    for (int s = 3; s <= 8; s++) begin
      tick(1);
      checks++;
      if (hex !== win(Msg, s - 1)) begin
        failures++;
        $display("FAIL left_window s=%0d hex=%h expected=%h", s, hex, win(Msg, s - 1));
      end
      if (s == 7) begin
        checks++;
        if (hex !== Bbal) begin
          failures++;
          $display("FAIL left_wrapped_window hex=%h expected=%h", hex, Bbal);
        end
      end
      checks++;
      if (wrap !== 1'b0) begin
        failures++;
        $display("FAIL left_wrap_idle_a s=%0d wrap=%b expected=0", s, wrap);
      end
      tick(1);
      checks++;
      if (wrap !== 1'b0) begin
        failures++;
        $display("FAIL left_wrap_idle_b s=%0d wrap=%b expected=0", s, wrap);
      end
      tick(1);
      checks++;
      if (pos !== 3'(s % 8)) begin
        failures++;
        $display("FAIL left_pos s=%0d pos=%0d expected=%0d", s, pos, s % 8);
      end
      checks++;
      if (wrap !== 1'(s == 8)) begin
        failures++;
        $display("FAIL left_wrap s=%0d wrap=%b expected=%b", s, wrap, s == 8);
      end
    end
    tick(1);
    checks++;
    if (wrap !== 1'b0) begin
      failures++;
      $display("FAIL left_wrap_one_cycle wrap=%b expected=0", wrap);
    end
    checks++;
    if (hex !== Alma) begin
      failures++;
      $display("FAIL left_back_to_start hex=%h expected=%h", hex, Alma);
    end
  endtask

  task automatic test_scroll_right();
    dir = 1'b1;
    tick(1);
    checks++;
    if (pos !== 3'd0) begin
      failures++;
      $display("FAIL right_early pos=%0d expected=0", pos);
    end
    tick(1);
    checks++;
    if (pos !== 3'd7 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL right_wrap pos=%0d wrap=%b expected 7/1", pos, wrap);
    end
    tick(1);
    checks++;
    if (hex !== Balm || wrap !== 1'b0) begin
      failures++;
      $display("FAIL right_window hex=%h wrap=%b expected %h/0", hex, wrap, Balm);
    end
    dir = 1'b0;
    tick(1);
    checks++;
    if (pos !== 3'd7) begin
      failures++;
      $display("FAIL dir_toggle_hold pos=%0d expected=7", pos);
    end
    dir = 1'b1;
    tick(1);
    checks++;
    if (pos !== 3'd6 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL dir_toggle_step pos=%0d wrap=%b expected 6/0", pos, wrap);
    end
  endtask

  task automatic test_pause();
    tick(1);
    checks++;
    if (hex !== Bbal) begin
      failures++;
      $display("FAIL pause_entry hex=%h expected=%h", hex, Bbal);
    end
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (pos !== 3'd6 || hex !== Bbal || wrap !== 1'b0) begin
        failures++;
        $display("FAIL pause_hold i=%0d pos=%0d hex=%h wrap=%b expected 6/%h/0",
                 i, pos, hex, wrap, Bbal);
      end
    end
    run = 1'b1;
    tick(1);
    checks++;
    if (pos !== 3'd6) begin
      failures++;
      $display("FAIL resume_early pos=%0d expected=6", pos);
    end
    tick(1);
    checks++;
    if (pos !== 3'd5) begin
      failures++;
      $display("FAIL resume_step pos=%0d expected=5", pos);
    end
  endtask

  task automatic test_restart();
    dir = 1'b0;
    tick(6);
    checks++;
    if (pos !== 3'd7) begin
      failures++;
      $display("FAIL restart_setup pos=%0d expected=7", pos);
    end
    tick(2);
    restart = 1'b1;
    tick(1);
    checks++;
    if (pos !== 3'd0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL restart_priority pos=%0d wrap=%b expected 0/0", pos, wrap);
    end
    restart = 1'b0;
    tick(1);
    checks++;
    if (hex !== Alma || wrap !== 1'b0) begin
      failures++;
      $display("FAIL restart_window hex=%h wrap=%b expected %h/0", hex, wrap, Alma);
    end
    tick(2);
    checks++;
    if (pos !== 3'd1) begin
      failures++;
      $display("FAIL restart_resume pos=%0d expected=1", pos);
    end
    tick(1);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(2);
    checks++;
    if (pos !== 3'd0) begin
      failures++;
      $display("FAIL restart_prescaler_clear pos=%0d expected=0", pos);
    end
    tick(1);
    checks++;
    if (pos !== 3'd1) begin
      failures++;
      $display("FAIL restart_full_period pos=%0d expected=1", pos);
    end
  endtask

  task automatic test_async_reset();
    tick(12);
    checks++;
    if (pos !== 3'd5) begin
      failures++;
      $display("FAIL async_setup pos=%0d expected=5", pos);
    end
    tick(1);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (hex !== Blank4 || pos !== 3'd0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL async_reset hex=%h pos=%0d wrap=%b expected %h/0/0",
               hex, pos, wrap, Blank4);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_start("after_async");
  endtask

  task automatic test_msg_change();
    logic [55:0] m2;
    m2 = Msg;
    m2[20:14] = 7'h00;
    msg = m2;
    #1;
    checks++;
    if (hex !== Lmat) begin
      failures++;
      $display("FAIL msg_no_comb hex=%h expected=%h", hex, Lmat);
    end
    tick(1);
    checks++;
    if (hex !== {7'h47, 7'h00, 7'h08, 7'h07} || pos !== 3'd1) begin
      failures++;
      $display("FAIL msg_update hex=%h pos=%0d expected %h/1",
               hex, pos, {7'h47, 7'h00, 7'h08, 7'h07});
    end
    msg = Msg;
  endtask

  initial begin
    test_reset();
    test_scroll_left();
    test_scroll_right();
    test_pause();
    test_restart();
    test_async_reset();
    test_msg_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_scroller.md
# hex_scroller

Parametrised marquee driver for the board's seven-segment digits. It shows a circular message of MSG_LEN glyphs through a window of N_DIGITS digits and advances the window by one glyph every STEP_CYCLES clocks. Scrolling runs left or right, and the bench or top level can pause or restart it. It replaces fixed per-digit word assignments in top-level display exercises; key or switch logic drives `run`, `dir` and `restart`.

## Interface
- N_DIGITS, 6, number of digits driven; 1 or more.
- MSG_LEN, 16, glyphs in the circular message; 1 or more; may be smaller than N_DIGITS.
- STEP_CYCLES, 12500000, clocks per scroll step (0.25 s at 50 MHz); 1 or more.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  1: prescaler counts and scrolling advances; 0: freeze.
- dir  input  1  0: scroll left (pos increments); 1: scroll right (pos decrements).
- restart  input  1  synchronous; forces pos and prescaler to 0.
- msg  input  MSG_LEN*7  glyph i at msg[7i+6:7i]; glyph 0 is the first character.
- hex  output  N_DIGITS*7  digit d at hex[7d+6:7d]; digit 0 is rightmost (hex0).
- pos  output  max(1,$clog2(MSG_LEN))  index of the glyph on the leftmost digit.
- wrap  output  1  one-cycle pulse when pos wraps.

## Operation
- Glyph format is active-low with bit order {g,f,e,d,c,b,a}. Blank is 7'h7F, A is 7'h08, L is 7'h47, M is 7'h6A, T is 7'h07, Y is 7'h11.
- Prescaler:
  - It is a counter running 0..STEP_CYCLES-1. It increments only while run=1.
  - At STEP_CYCLES-1 with run=1, it returns to 0 and asserts an internal step for that cycle.
  - It holds its value while run=0.
- Position:
  - On step with dir=0, pos becomes (pos+1) mod MSG_LEN.
  - On step with dir=1, pos becomes (pos+MSG_LEN-1) mod MSG_LEN.
  - Wrap conditions are an explicit compare, not power-of-2 overflow.
- Window mapping: digit N_DIGITS-1-k shows glyph (pos+k) mod MSG_LEN, for k in 0..N_DIGITS-1. If MSG_LEN < N_DIGITS, glyphs repeat across the window.
- wrap is registered with the pos update. It goes high for exactly one cycle when:
  - pos goes MSG_LEN-1 to 0 while dir=0, or
  - pos goes 0 to MSG_LEN-1 while dir=1.
- When MSG_LEN=1, pos stays 0 and wrap pulses on every step.
- restart:
  - Sets pos=0 and prescaler=0, and generates no step or wrap that cycle.
  - Has priority over a simultaneous step.
  - Counting resumes the next cycle if run=1.
- A change on dir takes effect at the next step. It does not reset the prescaler.
- A change on msg appears on hex one cycle later. It does not affect pos.
- Reset values: prescaler=0, pos=0, wrap=0, hex all 7'h7F (every digit blank).

## Timing
- hex is a register loaded every cycle from the current pos and msg, so hex lags pos by one clock.
- The first rising edge after reset deasserts loads the window for pos=0.
- Step to display: pos changes on the edge where prescaler=STEP_CYCLES-1 and run=1. hex reflects the new pos one edge later. wrap is high in the cycle after that first edge.
- With run held at 1, steps occur every STEP_CYCLES clocks exactly. With STEP_CYCLES=1, pos advances every clock.
- reset asserted mid-scroll immediately clears all registers and blanks hex, with no clock needed.
- There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use N_DIGITS=4, MSG_LEN=8, STEP_CYCLES=3, msg = "A L M A T Y blank blank" (glyph 0 = A).

1. Reset, then run=1, dir=0:
   - hex = 7'h7F on every digit during reset.
   - 1 cycle after release: digits 3..0 = A,L,M,A.
   - pos=1 after 3 edges.
   - hex = L,M,A,T after 4 edges.
2. Keep scrolling left for 8 steps:
   - pos sequence 1..7,0.
   - wrap high for one cycle only on the 7-to-0 transition.
   - At pos=6, the window shows blank,blank,A,L (the message wraps).
3. From pos=0 with dir=1:
   - After one step, pos=7 with a wrap pulse, and hex = blank,A,L,M.
   - Toggling dir mid-interval does not shorten the 3-clock step period.
4. run=0 for 10 cycles with prescaler=1:
   - pos, prescaler and hex stay constant.
   - After run=1 returns, the next step comes after 2 clocks.
5. restart on the same cycle as a step with pos=7, dir=0:
   - pos=0, prescaler=0, wrap stays 0.
   - hex = A,L,M,A one cycle later.
6. Assert reset asynchronously mid-step at pos=5:
   - Outputs clear within the same cycle: hex all blank, pos=0, wrap=0.
   - After release, the scenario 1 sequence repeats exactly.
